// File: rtl/regfile_param_bypass_if.sv
// Bus interface for regfile_param_bypass.
// master : request side (decode stage). It drives the write and read requests and receives the read data.
// slave  : register file side.
// Signals:
//   enable_w/address_w/In                   write port
//   enable_a/address_a, enable_b/address_b  read requests
//   OutA/valid_a, OutB/valid_b              registered read data and its update strobe
//   busy                                    clear sequence in progress
interface regfile_param_bypass_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              enable_w;
  logic [ADDR_W-1:0] address_w;
  logic [DATA_W-1:0] In;
  logic              enable_a;
  logic [ADDR_W-1:0] address_a;
  logic              enable_b;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] OutA;
  logic              valid_a;
  logic [DATA_W-1:0] OutB;
  logic              valid_b;
  logic              busy;

  modport master (
    output enable_w, address_w, In, enable_a, address_a, enable_b, address_b,
    input  OutA, valid_a, OutB, valid_b, busy
  );

  modport slave (
    input  enable_w, address_w, In, enable_a, address_a, enable_b, address_b,
    output OutA, valid_a, OutB, valid_b, busy
  );
endinterface

// File: rtl/regfile_param_bypass.sv
// regfile_param_bypass
// Parametrised register file with one write port and two read ports.
// Reads are registered, with a latency of one cycle, and use write-to-read bypass.
// After every reset a clear sequencer writes zero to each entry.
// The sequencer holds busy high for DEPTH cycles.
// Ports:
//   clk  single clock; all state updates on the posedge
//   rst  synchronous reset, active-high; has priority over every other input
//   bus  regfile_param_bypass_if.slave (write port, read ports A/B, busy)
// Optional build macro:
//   REGFILE_ZERO_REG_EN  entry 0 is hardwired to zero.
//                        Writes to address 0 are discarded, and reads of address 0 return 0.
module regfile_param_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                   clk,
  input logic                   rst,
  regfile_param_bypass_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              clr_last;

  assign clr_last = &clr_ptr;
  assign bus.busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clr_last) next_state = READY;
      READY:   next_state = READY;
      default: next_state = CLEAR;
    endcase
  end

  // Single physical write port shared by the clear sequencer and the user write.
  // A write in a reset cycle is dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_ptr;
    wr_data = '0;
    if (!rst) begin
      case (state)
        CLEAR: wr_en = 1'b1;
        READY: begin
          if (bus.enable_w && !(ZERO_REG && bus.address_w == '0)) begin
            wr_en   = 1'b1;
            wr_addr = bus.address_w;
            wr_data = bus.In;
          end
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  // The zero-register check takes precedence over bypass.
  // A same-cycle write to entry 0 must still read back as 0.
  always_comb begin
    rd_a = mem[bus.address_a];
    if (ZERO_REG && bus.address_a == '0)
      rd_a = '0;
    else if (bus.enable_w && bus.address_w == bus.address_a)
      rd_a = bus.In;
  end

  always_comb begin
    rd_b = mem[bus.address_b];
    if (ZERO_REG && bus.address_b == '0)
      rd_b = '0;
    else if (bus.enable_w && bus.address_w == bus.address_b)
      rd_b = bus.In;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr     <= '0;
      bus.OutA    <= '0;
      bus.OutB    <= '0;
      bus.valid_a <= 1'b0;
      bus.valid_b <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          // The pointer parks on the terminal count; the next reset restarts it from 0.
          if (!clr_last) clr_ptr <= clr_ptr + 1'b1;
          bus.valid_a <= 1'b0;
          bus.valid_b <= 1'b0;
        end
        READY: begin
          bus.valid_a <= bus.enable_a;
          bus.valid_b <= bus.enable_b;
          if (bus.enable_a) bus.OutA <= rd_a;
          if (bus.enable_b) bus.OutB <= rd_b;
        end
        default: begin
          bus.valid_a <= 1'b0;
          bus.valid_b <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_param_bypass.sv
// Scoreboard testbench for regfile_param_bypass (DATA_W=32, ADDR_W=5).
// The stimulus process pushes the expected read data for each issued read.
// The monitor pops that data and compares it against each valid output.
// While an output is not valid, the monitor checks that it holds its value.
module tb_regfile_param_bypass;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_param_bypass_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_param_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] q_a [$];
  logic [DATA_W-1:0] q_b [$];
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: samples on negedge, away from the active edge.
  logic [DATA_W-1:0] last_a = '0;
  logic [DATA_W-1:0] last_b = '0;
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.busy) begin
        check("busy_outA_zero", bus.OutA, '0);
        check("busy_outB_zero", bus.OutB, '0);
        check("busy_valid", {30'd0, bus.valid_a, bus.valid_b}, '0);
        last_a = '0;
        last_b = '0;
      end else begin
        if (bus.valid_a) begin
          if (q_a.size() == 0) check("unexpected_valid_a", 32'd1, 32'd0);
          else check("read_a", bus.OutA, q_a.pop_front());
          last_a = bus.OutA;
        end else check("hold_a", bus.OutA, last_a);
        if (bus.valid_b) begin
          if (q_b.size() == 0) check("unexpected_valid_b", 32'd1, 32'd0);
          else check("read_b", bus.OutB, q_b.pop_front());
          last_b = bus.OutB;
        end else check("hold_b", bus.OutB, last_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enable_w = 1'b0; bus.address_w = '0; bus.In = '0;
    bus.enable_a = 1'b0; bus.address_a = '0;
    bus.enable_b = 1'b0; bus.address_b = '0;
  endtask

  // One cycle of requests; the expected read data goes onto the scoreboard.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] aw, input logic [DATA_W-1:0] d,
                       input logic ea, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] xa,
                       input logic eb, input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] xb);
    bus.enable_w = we; bus.address_w = aw; bus.In = d;
    bus.enable_a = ea; bus.address_a = aa;
    bus.enable_b = eb; bus.address_b = ab;
    if (ea) q_a.push_back(xa);
    if (eb) q_b.push_back(xb);
    tick();
    idle_inputs();
  endtask

  // Counts the cycles with busy high, starting from the negedge after the reset edge.
  task automatic count_busy(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 32);
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    check("rst_busy", {31'd0, bus.busy}, 32'd1);
    check("rst_outs", bus.OutA | bus.OutB, '0);
    mon_on = 1'b1;
    rst = 1'b0;
    count_busy("busy_cycles");
  endtask

  logic [DATA_W-1:0] zexp;

  initial begin
    idle_inputs();
    tick();
    do_reset();

    // 1: every entry reads zero after the clear sequence.
    for (int i = 0; i < 32; i++)
      issue(1'b0, '0, '0, 1'b1, ADDR_W'(i), '0, 1'b1, ADDR_W'(31 - i), '0);

    // 2: write, then read the same entry on both ports the next cycle.
    issue(1'b1, 5'd4, 32'h0000_0444, 1'b0, '0, '0, 1'b0, '0, '0);
    issue(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0, '0);
    issue(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 5'd7, 32'hDEAD_BEEF);

    // 3: same-cycle bypass on A; B sees the stored entry 4.
    issue(1'b1, 5'd3, 32'h1234_5678, 1'b1, 5'd3, 32'h1234_5678, 1'b1, 5'd4, 32'h0000_0444);
    issue(1'b0, '0, '0, 1'b1, 5'd3, 32'h1234_5678, 1'b0, '0, '0);

    // 4: idle cycles; the monitor checks that the outputs hold.
    repeat (3) tick();

    // 6: behaviour of entry 0 depends on the zero-register build option.
`ifdef REGFILE_ZERO_REG_EN
    zexp = 32'h0000_0000;
`else
    zexp = 32'hFFFF_FFFF;
`endif
    issue(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, zexp, 1'b0, '0, '0);
    issue(1'b0, '0, '0, 1'b1, 5'd0, zexp, 1'b1, 5'd0, zexp);

    // 5: reset in the middle of a clear, together with a write to entry 9.
    issue(1'b1, 5'd9, 32'h0000_0099, 1'b0, '0, '0, 1'b0, '0, '0);
    issue(1'b0, '0, '0, 1'b1, 5'd9, 32'h0000_0099, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    bus.enable_w = 1'b1; bus.address_w = 5'd9; bus.In = 32'h0000_0077;
    tick();
    idle_inputs();
    rst = 1'b0;
    count_busy("busy_cycles_restart");
    issue(1'b0, '0, '0, 1'b1, 5'd9, '0, 1'b1, 5'd9, '0);
    issue(1'b0, '0, '0, 1'b1, 5'd7, '0, 1'b1, 5'd3, '0);

    repeat (3) tick();
    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end
endmodule
